// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC/nPC pair with one branch delay slot, imem request,
// IF/ID pipeline register, and a pending-redirect latch for memory waits.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_LE,
  input  logic        nPC_LE,
  input  logic        IF_ID_LE,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc,
  output logic        IF_ID_valid,
  output logic [31:0] nPC_out,
  output logic        redirect_pending
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        imem_req_q, imem_req_d;

  logic        hold;
  logic        br;
  logic        adv;
  logic [31:0] br_target;
  logic [31:0] npc_seq;

  always_comb begin
    hold      = ~(PC_LE & nPC_LE & IF_ID_LE);
    br        = branch_taken & if_id_valid_q;
    adv       = ~hold & imem_ready & imem_req_q;
    br_target = {branch_target[31:2], 2'b00};
    npc_seq   = npc_q + 32'd4;
  end

  always_comb begin
    pc_d          = pc_q;
    npc_d         = npc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    imem_req_d    = 1'b1;

    if (hold) begin
      // whole stage frozen; a stalled ID branch will be presented again
    end else if (adv) begin
      pc_d          = npc_q;
      if (br)                npc_d = br_target;
      else if (pend_valid_q) npc_d = pend_target_q;
      else                   npc_d = npc_seq;
      if_id_instr_d = imem_rdata;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b1;
      pend_valid_d  = 1'b0;
    end else begin
      // memory wait: bubble into ID, park any redirect until the delay slot is fetched
      if_id_instr_d = '0;
      if_id_pc_d    = pc_q;
      if_id_valid_d = 1'b0;
      if (br) begin
        pend_valid_d  = 1'b1;
        pend_target_d = br_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + 32'd4;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_valid_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      imem_req_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      imem_req_q    <= imem_req_d;
    end
  end

  assign imem_req         = imem_req_q;
  assign imem_addr        = pc_q;
  assign IF_ID_instr      = if_id_instr_q;
  assign IF_ID_pc         = if_id_pc_q;
  assign IF_ID_valid      = if_id_valid_q;
  assign nPC_out          = npc_q;
  assign redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes hand-computed post-edge
// state, a monitor pops and compares one entry after every rising edge.
module tb_fetch_stage;

  localparam logic [31:0] RP = 32'h0000_1000;
  localparam logic [31:0] K  = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PC_LE, nPC_LE, IF_ID_LE;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc;
  logic        IF_ID_valid;
  logic [31:0] nPC_out;
  logic        redirect_pending;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] npc;
    logic        pend;
    logic        req;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage #(.RESET_PC(RP)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .PC_LE            (PC_LE),
    .nPC_LE           (nPC_LE),
    .IF_ID_LE         (IF_ID_LE),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .IF_ID_instr      (IF_ID_instr),
    .IF_ID_pc         (IF_ID_pc),
    .IF_ID_valid      (IF_ID_valid),
    .nPC_out          (nPC_out),
    .redirect_pending (redirect_pending)
  );

  always #5 clk = ~clk;

  // memory returns a tagged copy of the address so instr and pc are distinguishable
  assign imem_rdata = imem_ready ? (imem_addr ^ K) : 32'hBAD0_BAD0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] le, input logic b, input logic [31:0] tgt,
                      input logic rdy, input logic ev, input logic [31:0] epc,
                      input logic [31:0] eaddr, input logic [31:0] enpc, input logic ep);
    exp_t e;
    {PC_LE, nPC_LE, IF_ID_LE} = le;
    branch_taken  = b;
    branch_target = tgt;
    imem_ready    = rdy;
    e.valid = ev;
    e.pc    = epc;
    e.instr = ev ? (epc ^ K) : 32'h0;
    e.addr  = eaddr;
    e.npc   = enpc;
    e.pend  = ep;
    e.req   = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_req",         {31'b0, imem_req},         {31'b0, e.req});
        check("IF_ID_valid",      {31'b0, IF_ID_valid},      {31'b0, e.valid});
        check("IF_ID_pc",         IF_ID_pc,                  e.pc);
        check("IF_ID_instr",      IF_ID_instr,               e.instr);
        check("imem_addr",        imem_addr,                 e.addr);
        check("nPC_out",          nPC_out,                   e.npc);
        check("redirect_pending", {31'b0, redirect_pending}, {31'b0, e.pend});
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    {PC_LE, nPC_LE, IF_ID_LE} = 3'b111;
    branch_taken  = 1'b0;
    branch_target = '0;
    imem_ready    = 1'b1;
    repeat (2) @(negedge clk);
    check("rst imem_addr", imem_addr, RP);
    check("rst nPC_out",   nPC_out,   RP + 32'd4);
    check("rst valid",     {31'b0, IF_ID_valid}, 32'd0);
    check("rst instr",     IF_ID_instr, 32'd0);
    check("rst imem_req",  {31'b0, imem_req}, 32'd0);
    rst_n = 1'b1;

    // startup and sequential fetch
    step(3'b111, 0, '0, 1, 0, RP,        RP,        RP+32'h4,  0);
    step(3'b111, 0, '0, 1, 1, RP,        RP+32'h4,  RP+32'h8,  0);
    step(3'b111, 0, '0, 1, 1, RP+32'h4,  RP+32'h8,  RP+32'hC,  0);
    // one-cycle hazard stall with PC at +8
    step(3'b000, 0, '0, 1, 1, RP+32'h4,  RP+32'h8,  RP+32'hC,  0);
    step(3'b111, 0, '0, 1, 1, RP+32'h8,  RP+32'hC,  RP+32'h10, 0);
    step(3'b111, 0, '0, 1, 1, RP+32'hC,  RP+32'h10, RP+32'h14, 0);
    // redirect with PC at +0x10: delay slot +0x14, then +0x40
    step(3'b111, 1, RP+32'h40, 1, 1, RP+32'h10, RP+32'h14, RP+32'h40, 0);
    step(3'b111, 0, '0, 1, 1, RP+32'h14, RP+32'h40, RP+32'h44, 0);
    step(3'b111, 0, '0, 1, 1, RP+32'h40, RP+32'h44, RP+32'h48, 0);
    step(3'b111, 0, '0, 1, 1, RP+32'h44, RP+32'h48, RP+32'h4C, 0);
    // redirect during a 3-cycle memory wait goes through the pend latch
    step(3'b111, 1, RP+32'h80, 0, 0, RP+32'h48, RP+32'h48, RP+32'h4C, 1);
    step(3'b111, 0, '0,        0, 0, RP+32'h48, RP+32'h48, RP+32'h4C, 1);
    step(3'b111, 0, '0,        0, 0, RP+32'h48, RP+32'h48, RP+32'h4C, 1);
    step(3'b111, 0, '0,        1, 1, RP+32'h48, RP+32'h4C, RP+32'h80, 0);
    step(3'b111, 0, '0,        1, 1, RP+32'h4C, RP+32'h80, RP+32'h84, 0);
    step(3'b111, 0, '0,        1, 1, RP+32'h80, RP+32'h84, RP+32'h88, 0);
    // branch against a bubble is ignored
    step(3'b111, 0, '0,         0, 0, RP+32'h84, RP+32'h84, RP+32'h88, 0);
    step(3'b111, 1, RP+32'h100, 0, 0, RP+32'h84, RP+32'h84, RP+32'h88, 0);
    step(3'b111, 1, RP+32'h100, 1, 1, RP+32'h84, RP+32'h88, RP+32'h8C, 0);
    // unaligned target is forced to word alignment
    step(3'b111, 1, RP+32'h143, 1, 1, RP+32'h88, RP+32'h8C,  RP+32'h140, 0);
    step(3'b111, 0, '0,         1, 1, RP+32'h8C, RP+32'h140, RP+32'h144, 0);
    // single low enable holds everything and masks the branch
    step(3'b101, 1, RP+32'h200, 1, 1, RP+32'h8C,  RP+32'h140, RP+32'h144, 0);
    step(3'b111, 0, '0,         1, 1, RP+32'h140, RP+32'h144, RP+32'h148, 0);
    // pending redirect survives a hazard hold
    step(3'b111, 1, RP+32'h300, 0, 0, RP+32'h144, RP+32'h144, RP+32'h148, 1);
    step(3'b011, 0, '0,         1, 0, RP+32'h144, RP+32'h144, RP+32'h148, 1);
    step(3'b111, 0, '0,         1, 1, RP+32'h144, RP+32'h148, RP+32'h300, 0);
    step(3'b111, 0, '0,         1, 1, RP+32'h148, RP+32'h300, RP+32'h304, 0);
    // nPC wraps modulo 2^32
    step(3'b111, 1, 32'hFFFF_FFF8, 1, 1, RP+32'h300,    RP+32'h304,    32'hFFFF_FFF8, 0);
    step(3'b111, 0, '0,            1, 1, RP+32'h304,    32'hFFFF_FFF8, 32'hFFFF_FFFC, 0);
    step(3'b111, 0, '0,            1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 0);
    step(3'b111, 0, '0,            1, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 0);
    step(3'b111, 1, 32'h500,       0, 0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0004, 1);

    // asynchronous reset between edges with pend set
    #3;
    rst_n = 1'b0;
    #1;
    check("async imem_addr", imem_addr, RP);
    check("async nPC_out",   nPC_out,   RP + 32'd4);
    check("async valid",     {31'b0, IF_ID_valid}, 32'd0);
    check("async pend",      {31'b0, redirect_pending}, 32'd0);
    check("async IF_ID_pc",  IF_ID_pc, 32'd0);
    check("async imem_req",  {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(3'b111, 0, '0, 1, 0, RP, RP,       RP+32'h4, 0);
    step(3'b111, 0, '0, 1, 1, RP, RP+32'h4, RP+32'h8, 0);

    @(negedge clk);
    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
